// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared definitions for the load/store unit: memop fields, access sizes,
// FSM state encoding and the alignment rule.
package ysyx_22040895_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int MEMOP_MEM   = 3;
  localparam int MEMOP_STORE = 2;

  // Natural alignment: an access of 2^size bytes must start on a 2^size boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SZ_H:    return offset[0];
      SZ_W:    return |offset[1:0];
      SZ_D:    return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_fmt.sv
// Combinational lane formatting: store data/mask placement and load
// extraction with sign or zero extension.
module ysyx_22040895_lsu_fmt
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        size,
  input  logic [2:0]        offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [7:0]        wmask,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]        base_mask;
  logic [DATA_W-1:0] shifted;
  logic              sx;

  always_comb begin
    base_mask = 8'h01;
    case (size)
      SZ_B:    base_mask = 8'h01;
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign wmask   = base_mask << offset;
  assign wdata   = store_data << {offset, 3'b000};
  assign shifted = rsp_data >> {offset, 3'b000};

  always_comb begin
    sx        = 1'b0;
    load_data = shifted;
    case (size)
      SZ_B: begin
        sx        = ~is_unsigned & shifted[7];
        load_data = {{(DATA_W-8){sx}}, shifted[7:0]};
      end
      SZ_H: begin
        sx        = ~is_unsigned & shifted[15];
        load_data = {{(DATA_W-16){sx}}, shifted[15:0]};
      end
      SZ_W: begin
        sx        = ~is_unsigned & shifted[31];
        load_data = {{(DATA_W-32){sx}}, shifted[31:0]};
      end
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: one instruction in flight, one aligned 64-bit memory
// request per access, formatted result handed to writeback.
module ysyx_22040895_lsu
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [3:0]        in_memop,
  input  logic              in_unsigned,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  lsu_state_e        state_reg, state_next;
  logic [2:0]        offset_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic              store_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              misalign_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic              req_wen_reg;
  logic [DATA_W-1:0] req_wdata_reg;
  logic [7:0]        req_wmask_reg;

  logic              accept;
  logic              in_is_mem;
  logic              in_misal;
  logic [1:0]        fmt_size;
  logic [2:0]        fmt_offset;
  logic [7:0]        fmt_wmask;
  logic [DATA_W-1:0] fmt_wdata;
  logic [DATA_W-1:0] fmt_load;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid & in_ready;
  assign in_is_mem = in_memop[MEMOP_MEM];
  assign in_misal  = misaligned(in_memop[1:0], in_addr[2:0]);

  // The store path is only needed at accept and the load path only in WAIT,
  // so one formatter serves both by selecting live or captured fields.
  assign fmt_size   = in_ready ? in_memop[1:0] : size_reg;
  assign fmt_offset = in_ready ? in_addr[2:0]  : offset_reg;

  ysyx_22040895_lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
    .size        (fmt_size),
    .offset      (fmt_offset),
    .is_unsigned (unsigned_reg),
    .store_data  (in_wdata),
    .rsp_data    (mem_rsp_rdata),
    .wmask       (fmt_wmask),
    .wdata       (fmt_wdata),
    .load_data   (fmt_load)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = (!in_is_mem || in_misal) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rsp_valid) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_reg    <= '0;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      store_reg     <= 1'b0;
      out_data_reg  <= '0;
      misalign_reg  <= 1'b0;
      req_addr_reg  <= '0;
      req_wen_reg   <= 1'b0;
      req_wdata_reg <= '0;
      req_wmask_reg <= '0;
    end else if (accept) begin
      offset_reg   <= in_addr[2:0];
      size_reg     <= in_memop[1:0];
      unsigned_reg <= in_unsigned;
      store_reg    <= in_memop[MEMOP_STORE];
      misalign_reg <= 1'b0;
      if (!in_is_mem) begin
        out_data_reg <= in_addr;
      end else if (in_misal) begin
        out_data_reg <= '0;
        misalign_reg <= 1'b1;
      end else begin
        req_addr_reg  <= {in_addr[ADDR_W-1:3], 3'b000};
        req_wen_reg   <= in_memop[MEMOP_STORE];
        req_wdata_reg <= in_memop[MEMOP_STORE] ? fmt_wdata : '0;
        req_wmask_reg <= in_memop[MEMOP_STORE] ? fmt_wmask : 8'h00;
      end
    end else if (state_reg == WAIT && mem_rsp_valid) begin
      out_data_reg <= store_reg ? '0 : fmt_load;
    end
  end

  assign out_valid     = (state_reg == DONE);
  assign out_data      = out_data_reg;
  assign out_misalign  = misalign_reg;
  assign mem_req_valid = (state_reg == REQ);
  assign mem_req_addr  = req_addr_reg;
  assign mem_req_wen   = req_wen_reg;
  assign mem_req_wdata = req_wdata_reg;
  assign mem_req_wmask = req_wmask_reg;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Scoreboard bench for the LSU: a driver pushes expected memory requests and
// results from a byte-level reference model; memory and writeback monitors pop and compare.
module tb_ysyx_22040895_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_addr, in_wdata;
  logic [3:0]  in_memop;
  logic        in_unsigned;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        out_misalign;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  ysyx_22040895_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_memop(in_memop), .in_unsigned(in_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_misalign(out_misalign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    int          lat;
  } out_t;

  req_t req_q[$];
  out_t out_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit fast = 1'b1;
  bit hold_rsp = 1'b0;
  bit force_rsp = 1'b0;
  int ready_low_until = 0;
  int out_low_until = 0;
  int accept_cyc = 0;
  int req_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Byte-array view of a load: gather the addressed bytes, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off, input int nb, input logic u);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!u && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic [3:0] op,
                       input logic u, input logic [63:0] rd, input bit chk_lat);
    out_t e;
    req_t r;
    int   nb, off;
    bit   ok;
    nb  = 1 << op[1:0];
    off = int'(a[2:0]);
    if (!op[3]) begin
      e.data = a; e.mis = 1'b0; e.lat = chk_lat ? 2 : 0;
    end else if ((a % nb) != 0) begin
      e.data = '0; e.mis = 1'b1; e.lat = chk_lat ? 2 : 0;
    end else begin
      r.addr  = a & ~64'h7;
      r.wen   = op[2];
      r.wdata = op[2] ? (wd << (8*off)) : 64'h0;
      r.wmask = 8'h00;
      if (op[2]) for (int i = 0; i < nb; i++) r.wmask[off+i] = 1'b1;
      r.rdata = rd;
      req_q.push_back(r);
      e.data = op[2] ? 64'h0 : ref_load(rd, off, nb, u);
      e.mis  = 1'b0;
      e.lat  = chk_lat ? 4 : 0;
    end
    out_q.push_back(e);
    $display("[TB] issue addr=%h wdata=%h memop=%b uns=%0d -> exp data=%h mis=%0d",
             a, wd, op, u, e.data, e.mis);
    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_memop = op; in_unsigned = u;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) accept_cyc = cyc;
    else fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && (out_q.size() != 0 || req_q.size() != 0); k++) @(negedge clk);
    if (out_q.size() != 0 || req_q.size() != 0) begin
      fail_now("drain_timeout");
      out_q.delete();
      req_q.delete();
    end
    @(negedge clk);
  endtask

  // Memory model and request monitor.
  initial begin
    bit          pend, held;
    int          dly;
    logic [63:0] pdata;
    req_t        last;
    pend = 1'b0; held = 1'b0; dly = 0; pdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = force_rsp;
      if (force_rsp) mem_rsp_rdata = {$urandom, $urandom};
      if (pend && !hold_rsp) begin
        if (dly == 0) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = pdata; pend = 1'b0;
        end else dly--;
      end
      if (cyc < ready_low_until) mem_req_ready = 1'b0;
      else mem_req_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; held = 1'b0;
      end else if (mem_req_valid) begin
        check("req_in_ready_low", {63'b0, in_ready}, 64'd0);
        if (held) begin
          check("req_addr_stable", mem_req_addr, last.addr);
          check("req_wdata_stable", mem_req_wdata, last.wdata);
          check("req_wmask_stable", {56'b0, mem_req_wmask}, {56'b0, last.wmask});
          check("req_wen_stable", {63'b0, mem_req_wen}, {63'b0, last.wen});
        end
        if (mem_req_ready) begin
          req_t e;
          held = 1'b0;
          req_count++;
          if (req_q.size() == 0) begin
            fail_now("unexpected_req");
          end else begin
            e = req_q.pop_front();
            check("req_addr", mem_req_addr, e.addr);
            check("req_wen", {63'b0, mem_req_wen}, {63'b0, e.wen});
            check("req_wdata", mem_req_wdata, e.wdata);
            check("req_wmask", {56'b0, mem_req_wmask}, {56'b0, e.wmask});
            pend  = 1'b1;
            dly   = fast ? 0 : int'($urandom_range(0, 2));
            pdata = e.rdata;
          end
        end else begin
          held = 1'b1;
          last.addr = mem_req_addr; last.wdata = mem_req_wdata;
          last.wmask = mem_req_wmask; last.wen = mem_req_wen;
        end
      end
    end
  end

  // Writeback monitor.
  initial begin
    bit          held, seen;
    logic [63:0] hd;
    logic        hm;
    held = 1'b0; seen = 1'b0; hd = '0; hm = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cyc < out_low_until) out_ready = 1'b0;
      else out_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rst) begin
        held = 1'b0; seen = 1'b0;
      end else if (out_valid) begin
        check("out_in_ready_low", {63'b0, in_ready}, 64'd0);
        if (held) begin
          check("out_data_stable", out_data, hd);
          check("out_mis_stable", {63'b0, out_misalign}, {63'b0, hm});
        end
        if (!seen && out_q.size() != 0 && out_q[0].lat != 0)
          check("latency", 64'(cyc - accept_cyc + 1), 64'(out_q[0].lat));
        seen = 1'b1;
        if (out_ready) begin
          out_t e;
          held = 1'b0; seen = 1'b0;
          if (out_q.size() == 0) begin
            fail_now("unexpected_out");
          end else begin
            e = out_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_misalign", {63'b0, out_misalign}, {63'b0, e.mis});
            $display("[TB] retire data=%h mis=%0d", out_data, out_misalign);
          end
        end else begin
          held = 1'b1; hd = out_data; hm = out_misalign;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_memop = '0; in_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_mis", {63'b0, out_misalign}, 64'd0);
    check("rst_req_addr", mem_req_addr, 64'd0);
    check("rst_req_wdata", mem_req_wdata, 64'd0);
    check("rst_req_wmask", {56'b0, mem_req_wmask}, 64'd0);
    check("rst_req_wen", {63'b0, mem_req_wen}, 64'd0);

    fast = 1'b1;
    issue(64'h8000_0004, 64'h1122334455667788, 4'b1110, 1'b0, 64'h0, 1'b1);
    drain();
    issue(64'h8000_0003, 64'h0, 4'b1000, 1'b0, 64'h00000000_80000000, 1'b1);
    drain();
    issue(64'h8000_0003, 64'h0, 4'b1000, 1'b1, 64'h00000000_80000000, 1'b1);
    drain();
    issue(64'h8000_0001, 64'h0, 4'b1001, 1'b0, 64'h0, 1'b1);
    drain();
    issue(64'h1234, 64'hdead, 4'b0000, 1'b0, 64'h0, 1'b1);
    drain();

    // Backpressure on both sides of the unit.
    ready_low_until = cyc + 7;
    out_low_until   = cyc + 14;
    issue(64'h8000_0018, 64'hA5A5_0102_0304_5A5A, 4'b1111, 1'b0, 64'h0, 1'b0);
    drain();
    ready_low_until = cyc + 7;
    out_low_until   = cyc + 14;
    issue(64'h8000_0026, 64'h0, 4'b1001, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0);
    drain();

    // Reset while waiting for a response, followed by a late response.
    hold_rsp = 1'b1;
    rc = req_count;
    issue(64'h8000_0010, 64'h0, 4'b1011, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int k = 0; k < 50 && req_count == rc; k++) @(negedge clk);
    if (req_count == rc) fail_now("wait_req_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    out_q.delete();
    req_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    hold_rsp = 1'b0;
    @(negedge clk);
    check("rstwait_in_ready", {63'b0, in_ready}, 64'd1);
    check("rstwait_out_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1 force_rsp = 1'b1;
    @(posedge clk); #1 force_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("late_rsp_out_valid", {63'b0, out_valid}, 64'd0);
      check("late_rsp_in_ready", {63'b0, in_ready}, 64'd1);
    end

    fast = 1'b0;
    for (int t = 0; t < 300; t++) begin
      logic [63:0] a, wd, rd;
      logic [3:0]  op;
      a  = {32'h0000_0000 | $urandom_range(0, 1) << 31, $urandom};
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op[3] = 1'b1;
      if ($urandom_range(0, 1) != 0) a[2:0] = a[2:0] & ~((3'd1 << op[1:0]) - 3'd1);
      issue(a, wd, op, 1'($urandom_range(0, 1)), rd, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
